// File: rtl/audio_pkg.sv
// Shared audio constants: sample widths, pacing dividers, CPU I/O addresses
// and the layout of the status word the CPU reads back.
package audio_pkg;

  localparam int AUDIO_WIDTH          = 10;
  localparam int AUDIO_SAMPLE_DIV_8K  = 6250;
  localparam int AUDIO_SAMPLE_DIV_44K = 1134;

  localparam logic [15:0] AUDIO_DATA_ADDR   = 16'd4098;
  localparam logic [15:0] AUDIO_STATUS_ADDR = 16'd4099;

  localparam int STATUS_LEVEL_LSB    = 0;
  localparam int STATUS_LEVEL_MSB    = 4;
  localparam int STATUS_FULL_BIT     = 5;
  localparam int STATUS_EMPTY_BIT    = 6;
  localparam int STATUS_UNDERRUN_BIT = 7;
  localparam int STATUS_OVERFLOW_BIT = 8;

  // Field order matches the bit positions above (overflow is bit 8).
  typedef struct packed {
    logic       overflow;
    logic       underrun;
    logic       empty;
    logic       full;
    logic [4:0] level;
  } audio_status_t;

  function automatic audio_status_t audio_status_pack(
    input logic [4:0] level,
    input logic       full,
    input logic       empty,
    input logic       underrun,
    input logic       overflow
  );
    audio_status_t s;
    s.level    = level;
    s.full     = full;
    s.empty    = empty;
    s.underrun = underrun;
    s.overflow = overflow;
    return s;
  endfunction

endpackage

// File: rtl/sample_rate_divider.sv
// Free-running period counter with a registered one-cycle tick at each wrap;
// freezes (no count, no tick) while enable is low.
module sample_rate_divider #(
  parameter int DIV = 6250
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_d, count_q;
  logic             tick_d, tick_q;

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Sample FIFO plus rate pacer feeding the PWM duty-cycle input.
// Define AUDIO_FIFO_IDLE_MIDSCALE_EN to park duty_cycle at midscale on underrun.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = AUDIO_WIDTH,
  parameter int SAMPLE_DIV = AUDIO_SAMPLE_DIV_8K
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     clear_flags,
  output logic [WIDTH-1:0]         duty_cycle,
  output logic                     sample_tick,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     underrun,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
`ifdef AUDIO_FIFO_IDLE_MIDSCALE_EN
  localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic             tick;
  logic             pop, push, drop, under_evt;

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [LVL_W-1:0] level_d, level_q;
  logic             full_d, full_q;
  logic             empty_d, empty_q;
  logic [WIDTH-1:0] duty_d, duty_q;
  logic             underrun_d, underrun_q;
  logic             overflow_d, overflow_q;

  sample_rate_divider #(
    .DIV (SAMPLE_DIV)
  ) u_divider (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // A pop frees a slot in the same cycle, so a push against a full FIFO
  // is still accepted when it coincides with a tick.
  assign pop       = tick & ~empty_q;
  assign push      = wr_en & (~full_q | pop);
  assign drop      = wr_en & full_q & ~pop;
  assign under_evt = tick & empty_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    duty_d     = duty_q;
    underrun_d = under_evt | (underrun_q & ~clear_flags);
    overflow_d = drop | (overflow_q & ~clear_flags);

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      duty_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
`ifdef AUDIO_FIFO_IDLE_MIDSCALE_EN
    else if (under_evt) begin
      duty_d = MIDSCALE;
    end
`endif

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      duty_q     <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      duty_q     <= duty_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and level already discard it.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign duty_cycle  = duty_q;
  assign sample_tick = tick;
  assign level       = level_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
Sample buffer and rate pacer between the CPU's memory-mapped audio write port and the PWM serializer. The CPU pushes 10-bit duty-cycle samples in bursts. The block releases exactly one sample per sample period, so audio pitch no longer depends on the software loop timing. Its duty_cycle output drives the PWM serializer's duty-cycle input directly. Its status outputs are exposed to the CPU through an I/O read address.

Parameters:
DEPTH, 16, number of FIFO entries; power of two, at least 2
WIDTH, 10, sample width; matches the PWM duty-cycle width
SAMPLE_DIV, 6250, clock cycles per sample period (50 MHz / 6250 = 8 kHz); at least 2

Ports:
clock  in  1  system clock (50 MHz domain)
reset  in  1  synchronous, active-high reset
enable  in  1  playback enable; when low, the pacer is frozen
wr_en  in  1  one-cycle push strobe from the CPU audio address decode
wr_data  in  WIDTH  sample to push
clear_flags  in  1  one-cycle strobe; clears the underrun and overflow flags
duty_cycle  out  WIDTH  current sample, registered
sample_tick  out  1  one-cycle pulse at each sample-period boundary
level  out  $clog2(DEPTH)+1  number of entries currently stored
full  out  1  high when level == DEPTH
empty  out  1  high when level == 0
underrun  out  1  sticky: a tick occurred while the FIFO was empty
overflow  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, active-high):
  - FIFO pointers and level go to 0; full=0, empty=1.
  - Divider counter goes to 0; sample_tick=0.
  - duty_cycle=0; underrun=0; overflow=0.
  - Reset takes effect mid-burst or mid-period. Stored contents are discarded.
- Divider:
  - While enable=1, the counter runs 0..SAMPLE_DIV-1 and wraps to 0.
  - sample_tick is registered and is high in the cycle after the counter reaches SAMPLE_DIV-1. Period is exactly SAMPLE_DIV cycles.
  - While enable=0, the counter holds its value, no ticks are issued, and pushes are still accepted.
- Pop:
  - On a cycle where sample_tick=1 and the FIFO is not empty, duty_cycle takes the head entry at the next clock edge and level decrements.
  - Latency from tick to duty_cycle update is 1 cycle.
- Underrun:
  - On a tick with the FIFO empty, underrun is set and duty_cycle holds its last value.
  - A push in the same cycle as that tick does not bypass to the output. It is stored, and the tick still counts as an underrun.
- Push:
  - wr_en=1 is accepted when full=0, or when a pop happens in the same cycle. An accepted push stores wr_data at the tail.
  - Simultaneous push and pop leaves level unchanged.
  - A push with full=1 and no pop is dropped, sets overflow, and leaves contents unchanged.
- Pointers: wrap modulo DEPTH. level is the explicit count (0..DEPTH), not a pointer difference.
- Flags:
  - clear_flags=1 clears underrun and overflow.
  - If a set event coincides with clear_flags, the set wins.
- Status: full, empty and level are registered and valid the cycle after the edge that changed them.

Optional Feature:
- Macro: AUDIO_FIFO_IDLE_MIDSCALE_EN.
- When defined, an underrun tick loads duty_cycle with 2**(WIDTH-1) (512 at WIDTH=10) instead of holding. This silences a stuck output level.
- When undefined, duty_cycle holds its last value on underrun, as described in Behaviour.
- Reset value is 0 in both builds.

Decomposition:
- Package audio_pkg holds:
  - AUDIO_WIDTH=10
  - AUDIO_SAMPLE_DIV_8K=6250
  - AUDIO_SAMPLE_DIV_44K=1134
  - I/O address constants AUDIO_DATA_ADDR=4098 and AUDIO_STATUS_ADDR=4099
  - the status-word bit positions: [4:0] level, [5] full, [6] empty, [7] underrun, [8] overflow
- One sub-module, sample_rate_divider (counter plus tick generation), reused later for other paced I/O.
- FIFO storage is inline, as a register array.

Test Plan (DEPTH=4, SAMPLE_DIV=4 unless noted):
- Reset, enable=1, no pushes -> first tick on cycle 4, underrun=1 at cycle 5, duty_cycle stays 0; with the macro defined, duty_cycle=512.
- Push 100, 200, 300 back-to-back, enable=1 -> level 3; duty_cycle becomes 100, 200, 300 at 4-cycle spacing; level returns to 0; the next tick sets underrun.
- Push 5 samples with enable=0 -> level=4, full=1, overflow=1; the 5th sample is never output; clear_flags clears overflow.
- Full FIFO, wr_en coincident with a pop tick -> push accepted, level stays 4, overflow stays 0.
- Reset asserted mid-playback at level 2 -> next cycle level=0, empty=1, duty_cycle=0, flags 0; divider restarts and the next tick comes SAMPLE_DIV cycles after reset deasserts.
- SAMPLE_DIV=6250 smoke test -> ticks exactly 6250 cycles apart across 3 periods; enable toggled low for 100 cycles delays the next tick by exactly 100 cycles.
